// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR user-port arbiter.
// Holds the FSM state encoding, requester index names and the
// round-robin pointer advance helper.
package ddr_arb_pkg;

  localparam int unsigned ST_W = 3;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_W_ADDR = 3'd1;
  localparam logic [2:0] ST_W_DATA = 3'd2;
  localparam logic [2:0] ST_R_ADDR = 3'd3;
  localparam logic [2:0] ST_R_DATA = 3'd4;

  // Requester slots on the shared port
  localparam int unsigned REQ_CONV = 0;
  localparam int unsigned REQ_POOL = 1;
  localparam int unsigned REQ_FC   = 2;
  localparam int unsigned REQ_UART = 3;

  // Next round-robin start position, wrapping n-1 -> 0
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Bus bundle between the engines, the arbiter and the DDR3 user port.
// req_* : per-requester packed channels (slice i belongs to requester i),
//         req_rdata is broadcast.
// ddr_* : single controller-side AXI-style port.
// slave  : view used by the arbiter.
// master : view used by the surrounding engines and controller.
interface ddr_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned STRB_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned ID_W    = 4
);

  // Requester side
  logic [NUM_REQ-1:0]        req_awvalid;
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ*ADDR_W-1:0] req_awaddr;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*LEN_W-1:0]  req_awlen;
  logic [NUM_REQ*LEN_W-1:0]  req_arlen;
  logic [NUM_REQ-1:0]        req_awap;
  logic [NUM_REQ-1:0]        req_arap;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*STRB_W-1:0] req_wstrb;
  logic [NUM_REQ-1:0]        req_awready;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ-1:0]        req_wready;
  logic [NUM_REQ-1:0]        req_wlast;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rlast;
  logic [DATA_W-1:0]         req_rdata;

  // Controller side
  logic [ADDR_W-1:0] ddr_awaddr;
  logic [ADDR_W-1:0] ddr_araddr;
  logic [LEN_W-1:0]  ddr_awlen;
  logic [LEN_W-1:0]  ddr_arlen;
  logic [ID_W-1:0]   ddr_awid;
  logic [ID_W-1:0]   ddr_arid;
  logic              ddr_awap;
  logic              ddr_arap;
  logic              ddr_awvalid;
  logic              ddr_arvalid;
  logic              ddr_awready;
  logic              ddr_arready;
  logic [DATA_W-1:0] ddr_wdata;
  logic [STRB_W-1:0] ddr_wstrb;
  logic              ddr_wready;
  logic              ddr_wlast;
  logic [ID_W-1:0]   ddr_wid;
  logic [DATA_W-1:0] ddr_rdata;
  logic              ddr_rvalid;
  logic              ddr_rlast;
  logic [ID_W-1:0]   ddr_rid;

  modport slave (
    input  req_awvalid, req_arvalid, req_awaddr, req_araddr, req_awlen, req_arlen,
           req_awap, req_arap, req_wdata, req_wstrb,
    output req_awready, req_arready, req_wready, req_wlast, req_rvalid, req_rlast, req_rdata,
    output ddr_awaddr, ddr_araddr, ddr_awlen, ddr_arlen, ddr_awid, ddr_arid,
           ddr_awap, ddr_arap, ddr_awvalid, ddr_arvalid, ddr_wdata, ddr_wstrb,
    input  ddr_awready, ddr_arready, ddr_wready, ddr_wlast, ddr_wid,
           ddr_rdata, ddr_rvalid, ddr_rlast, ddr_rid
  );

  modport master (
    output req_awvalid, req_arvalid, req_awaddr, req_araddr, req_awlen, req_arlen,
           req_awap, req_arap, req_wdata, req_wstrb,
    input  req_awready, req_arready, req_wready, req_wlast, req_rvalid, req_rlast, req_rdata,
    input  ddr_awaddr, ddr_araddr, ddr_awlen, ddr_arlen, ddr_awid, ddr_arid,
           ddr_awap, ddr_arap, ddr_awvalid, ddr_arvalid, ddr_wdata, ddr_wstrb,
    output ddr_awready, ddr_arready, ddr_wready, ddr_wlast, ddr_wid,
           ddr_rdata, ddr_rvalid, ddr_rlast, ddr_rid
  );

endinterface

// File: rtl/ddr_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// req : request vector, ptr : highest-priority slot this round
// idx : first requesting slot at or after ptr (wrapping), hit : any request
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [IDX_W-1:0] cand;

  // Walk the slots in priority order; the first requester found wins
  always_comb begin
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin owner of the single DDR3 user port.
// One write or read burst owns the port from address handshake to last beat.
// clk, rst_n     : clock, asynchronous active-low reset
// ddr_init_done  : controller ready; gates new grants only
// bus            : requester and controller channels (slave view)
// id_err         : sticky, set when a returned wid/rid differs from the owner
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned STRB_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned ID_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ddr_init_done,
  ddr_port_arbiter_if.slave bus,
  output logic              id_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ST_W-1:0]    state, state_nxt;
  logic [IDX_W-1:0]   grant_idx, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_hit;
  logic [NUM_REQ-1:0] req_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               id_bad;

  assign req_any  = bus.req_awvalid | bus.req_arvalid;
  assign grant_id = ID_W'(grant_idx);

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req_any),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .hit (pick_hit)
  );

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  // Next-state: grant from IDLE, hold ownership until the last beat
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (ddr_init_done && pick_hit) begin
          grant_nxt = pick_idx;
          // A requester raising both channels gets its write first
          state_nxt = bus.req_awvalid[pick_idx] ? ST_W_ADDR : ST_R_ADDR;
        end
      end
      ST_W_ADDR: if (bus.ddr_awready) state_nxt = ST_W_DATA;
      ST_R_ADDR: if (bus.ddr_arready) state_nxt = ST_R_DATA;
      ST_W_DATA: begin
        if (bus.ddr_wready && bus.ddr_wlast) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
        end
      end
      ST_R_DATA: begin
        if (bus.ddr_rvalid && bus.ddr_rlast) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload mux from the granted slice to the controller
  always_comb begin
    bus.ddr_awaddr = '0;
    bus.ddr_araddr = '0;
    bus.ddr_awlen  = '0;
    bus.ddr_arlen  = '0;
    bus.ddr_awap   = 1'b0;
    bus.ddr_arap   = 1'b0;
    bus.ddr_wdata  = '0;
    bus.ddr_wstrb  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        bus.ddr_awaddr = bus.req_awaddr[i*ADDR_W +: ADDR_W];
        bus.ddr_araddr = bus.req_araddr[i*ADDR_W +: ADDR_W];
        bus.ddr_awlen  = bus.req_awlen[i*LEN_W +: LEN_W];
        bus.ddr_arlen  = bus.req_arlen[i*LEN_W +: LEN_W];
        bus.ddr_awap   = bus.req_awap[i];
        bus.ddr_arap   = bus.req_arap[i];
        bus.ddr_wdata  = bus.req_wdata[i*DATA_W +: DATA_W];
        bus.ddr_wstrb  = bus.req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Handshake routing: only the owner sees ready/valid/last
  always_comb begin
    grant_oh        = NUM_REQ'(1) << grant_idx;
    bus.ddr_awid    = grant_id;
    bus.ddr_arid    = grant_id;
    bus.ddr_awvalid = (state == ST_W_ADDR);
    bus.ddr_arvalid = (state == ST_R_ADDR);
    bus.req_awready = ((state == ST_W_ADDR) && bus.ddr_awready) ? grant_oh : '0;
    bus.req_arready = ((state == ST_R_ADDR) && bus.ddr_arready) ? grant_oh : '0;
    bus.req_wready  = ((state == ST_W_DATA) && bus.ddr_wready) ? grant_oh : '0;
    bus.req_wlast   = ((state == ST_W_DATA) && bus.ddr_wlast)  ? grant_oh : '0;
    bus.req_rvalid  = ((state == ST_R_DATA) && bus.ddr_rvalid) ? grant_oh : '0;
    bus.req_rlast   = ((state == ST_R_DATA) && bus.ddr_rlast)  ? grant_oh : '0;
    bus.req_rdata   = bus.ddr_rdata;
  end

  // Beats tagged for another owner are still forwarded, only flagged
  assign id_bad = ((state == ST_W_DATA) && bus.ddr_wready && (bus.ddr_wid != grant_id)) ||
                  ((state == ST_R_DATA) && bus.ddr_rvalid && (bus.ddr_rid != grant_id));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      id_err <= 1'b0;
    else if (id_bad) id_err <= 1'b1;
  end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Round-robin arbiter that shares the single DDR3 controller AXI-style user port among the compute and I/O engines (conv, pool, fc, uart), replacing direct wire contention on the shared address, data and handshake nets. One transaction owns the port at a time. Each transaction is a write burst or a read burst, and ownership lasts until its last beat. Sits in the system top, between the engine units and the DDR3 IP.

## Interface
- NUM_REQ, 4, number of requesters; index 0 = conv, 1 = pool, 2 = fc, 3 = uart
- ADDR_W, 28, address width
- DATA_W, 256, data width on the DDR side
- STRB_W, 32, byte-strobe width (DATA_W/8)
- LEN_W, 4, burst length field width
- ID_W, 4, transaction ID width; must satisfy ID_W ≥ clog2(NUM_REQ)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ddr_init_done  in  1  DDR ready; no grant is issued while low
- req_awvalid, req_arvalid  in  NUM_REQ  per-requester address-valid signals
- req_awaddr, req_araddr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i
- req_awlen, req_arlen  in  NUM_REQ*LEN_W  packed burst lengths
- req_awap, req_arap  in  NUM_REQ  auto-precharge bits
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_wstrb  in  NUM_REQ*STRB_W  packed write strobes
- req_awready, req_arready  out  NUM_REQ  address accepted
- req_wready, req_wlast  out  NUM_REQ  write beat taken / last write beat
- req_rvalid, req_rlast  out  NUM_REQ  read beat / last read beat
- req_rdata  out  DATA_W  read data broadcast to all requesters
- ddr_awaddr, ddr_araddr  out  ADDR_W  controller addresses
- ddr_awlen, ddr_arlen  out  LEN_W  controller burst lengths
- ddr_awid, ddr_arid  out  ID_W  transaction IDs
- ddr_awap, ddr_arap  out  1  auto-precharge bits
- ddr_awvalid, ddr_arvalid  out  1  address valid
- ddr_awready, ddr_arready  in  1  address ready
- ddr_wdata  out  DATA_W  write data
- ddr_wstrb  out  STRB_W  write strobes
- ddr_wready, ddr_wlast  in  1  controller pulls a write beat / last beat
- ddr_wid  in  ID_W  ID of the pulled write beat
- ddr_rdata  in  DATA_W  read data
- ddr_rvalid, ddr_rlast  in  1  read beat valid / last read beat
- ddr_rid  in  ID_W  ID of the read beat
- id_err  out  1  sticky flag: ID mismatch seen

## Operation
- FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA.
- In IDLE with ddr_init_done=1, scan requesters starting at rr_ptr. The first requester with awvalid or arvalid wins.
- If the winner asserts both, the write goes first. grant_idx is registered.
- From IDLE, go to W_ADDR or R_ADDR.
- W_ADDR / R_ADDR:
  - ddr_aw*/ar* are driven from the granted slice; ddr_awid/arid = grant_idx, zero-extended.
  - Valid is driven high while in the state. req_awready[grant] = ddr_awready, combinational.
  - On handshake, go to W_DATA or R_DATA.
- W_DATA:
  - ddr_wdata/wstrb are muxed from the granted slice.
  - req_wready[grant] = ddr_wready; req_wlast[grant] = ddr_wlast.
  - On ddr_wready && ddr_wlast, go to IDLE.
- R_DATA:
  - req_rvalid[grant] = ddr_rvalid; req_rlast[grant] = ddr_rlast.
  - On ddr_rvalid && ddr_rlast, go to IDLE.
- On return to IDLE, rr_ptr becomes grant_idx+1, wrapping NUM_REQ-1 → 0.
- ID check: if ddr_wid (on ddr_wready) or ddr_rid (on ddr_rvalid) ≠ grant_idx, set id_err. Data is still forwarded. id_err clears only on reset.
- Non-granted requesters see every ready, valid and last output at 0.

## Timing
- Reset values: FSM=IDLE, rr_ptr=0, grant_idx=0, id_err=0; all ddr_*valid and all req_* handshake outputs are 0.
- Grant latency: a request at cycle t (state IDLE) produces ddr_*valid at t+1.
- Minimum gap between transactions: one IDLE cycle.
- Requester valid dropping during W_ADDR/R_ADDR is a protocol violation; the request stays latched by the grant.
- ddr_init_done falling mid-transaction: the current burst completes; no new grant is issued.
- Async reset mid-burst: immediate return to IDLE. The DDR side is expected to be reset alongside.

## Structure
- Shared package ddr_arb_pkg holds: state enum; requester index constants REQ_CONV/REQ_POOL/REQ_FC/REQ_UART.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs are request vector and rr_ptr; outputs are index and hit.

## Test plan
- All four requesters raise arvalid at once with arlen=3 → grants in order 0,1,2,3; each receives 4 rvalid beats; ddr_arid = 0,1,2,3.
- Requester 2 raises awvalid and arvalid together → write burst (awid=2) completes first, then the read.
- ddr_init_done=0 with requests pending → ddr_awvalid/arvalid stay 0; first grant one cycle after init_done rises.
- Read with rid=1 while grant=3 → data routed to requester 3; id_err=1 and stays 1.
- rst_n pulsed low mid-W_DATA → all outputs 0 immediately; next grant starts from requester 0.
- After grant to requester 3 completes, requesters 0 and 3 both request → requester 0 is granted (wrap-around).
